// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_detect_pkg;

    localparam int W_MIN  = 2;
    localparam int W_MAX  = 16;
    localparam int CW_MIN = 2;
    localparam int CW_MAX = 32;

    localparam logic [3:0] PAT_RST_DEFAULT = 4'b1011;

    // Fill counter only has to reach W-1.
    function automatic int fill_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; present only when SEQDET_COUNT_EN is defined.
`ifdef SEQDET_COUNT_EN
module seq_match_cnt
    import seq_detect_pkg::*;
#(
    parameter int CW = 8
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear has priority over a simultaneous increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/seq_detect_param.sv
// Mealy serial pattern detector with loadable pattern and overlap control.
// Optional saturating match counter enabled by the SEQDET_COUNT_EN macro.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int           W       = 4,
    parameter logic [W-1:0] PAT_RST = W'(PAT_RST_DEFAULT)
`ifdef SEQDET_COUNT_EN
    ,
    parameter int           CW      = 8
`endif
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          x_in,
    input  logic          x_valid,
    input  logic          overlap,
    input  logic          pat_load,
    input  logic [W-1:0]  pat_in,
    output logic          y_out,
    output logic          y_reg
`ifdef SEQDET_COUNT_EN
    ,
    input  logic          cnt_clr,
    output logic [CW-1:0] match_cnt
`endif
);

    localparam int             FW       = fill_width(W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(W - 1);

    logic [W-1:0]  pat_q,  pat_d;
    logic [W-2:0]  hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          y_reg_q, y_reg_d;
    logic          consume;
    logic          full;
    logic [W-1:0]  window;

    always_comb begin
        consume = x_valid & ~pat_load;
        window  = {hist_q, x_in};
        full    = (fill_q == FILL_MAX);
        // Gated by rst so the output is quiet for the whole reset interval.
        y_out   = rst & consume & full & (window == pat_q);

        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        y_reg_d = y_out;

        if (pat_load) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (consume) begin
            hist_d = window[W-2:0];
            if (y_out && !overlap) begin
                fill_d = '0;
            end else if (!full) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q   <= PAT_RST;
            hist_q  <= '0;
            fill_q  <= '0;
            y_reg_q <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            y_reg_q <= y_reg_d;
        end
    end

    assign y_reg = y_reg_q;

`ifdef SEQDET_COUNT_EN
    seq_match_cnt #(
        .CW (CW)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (y_out),
        .cnt (match_cnt)
    );
`endif

endmodule
